// File: rtl/r_exec_sequencer_pkg.sv
// Shared constants for the R-type issue/writeback sequencer: field positions,
// opcode/funct codes and the FSM state encoding.
package r_exec_sequencer_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd33;
  localparam logic [5:0] FN_AND   = 6'd34;
  localparam logic [5:0] FN_OR    = 6'd35;
  localparam logic [5:0] FN_XOR   = 6'd36;
  localparam logic [5:0] FN_NOR   = 6'd37;
  localparam logic [5:0] FN_SLL   = 6'd38;
  localparam logic [5:0] FN_SRL   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [31:0] word);
    return (word[OPC_MSB:OPC_LSB] == OP_RTYPE) &&
           (word[FN_MSB:FN_LSB] >= FN_ADD) &&
           (word[FN_MSB:FN_LSB] <= FN_SLT);
  endfunction

endpackage

// File: rtl/r_exec_sequencer_regfile.sv
// 32-entry register file: one write port, three combinational read ports,
// asynchronous clear, entry 0 hardwired to zero.
module r_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [4:0]        raddr_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
  assign rdata_c = (raddr_c == 5'd0) ? '0 : regs[raddr_c];

endmodule

// File: rtl/r_exec_sequencer.sv
// Four-state issue/writeback controller feeding an external R-type ALU and
// writing its result back into the local register file.
module r_exec_sequencer
  import r_exec_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [31:0]       inst_in,
  output logic              inst_ready,
  output logic [31:0]       inst_reg,
  output logic [DATA_W-1:0] alu_i1,
  output logic [DATA_W-1:0] alu_i2,
  output logic [4:0]        shift,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              illegal,
  output logic              busy,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  logic [DATA_W-1:0] result_reg;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  r_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (state == ST_WB),
    .waddr  (inst_reg[RD_MSB:RD_LSB]),
    .wdata  (result_reg),
    .raddr_a(inst_reg[RS_MSB:RS_LSB]),
    .rdata_a(rs_data),
    .raddr_b(inst_reg[RT_MSB:RT_LSB]),
    .rdata_b(rt_data),
    .raddr_c(dbg_addr),
    .rdata_c(dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      inst_reg   <= '0;
      alu_i1     <= '0;
      alu_i2     <= '0;
      shift      <= '0;
      result_reg <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      busy       <= 1'b0;
      inst_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (inst_valid && inst_ready) begin
            inst_reg   <= inst_in;
            inst_ready <= 1'b0;
            busy       <= 1'b1;
            // Decode legality at acceptance so the pulse lands in the DECODE cycle.
            illegal    <= !is_legal(inst_in);
            state      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_i1  <= rs_data;
          alu_i2  <= rt_data;
          shift   <= inst_reg[SH_MSB:SH_LSB];
          illegal <= 1'b0;
          if (illegal) begin
            inst_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_reg <= alu_out;
          done       <= 1'b1;
          state      <= ST_WB;
        end
        ST_WB: begin
          done       <= 1'b0;
          inst_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_exec_sequencer.sv
// Directed plus randomized bench for r_exec_sequencer with a behavioural ALU
// and a register-array reference model.
module tb_r_exec_sequencer;
  import r_exec_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst_in;
  logic        inst_ready;
  logic [31:0] inst_reg;
  logic [31:0] alu_i1;
  logic [31:0] alu_i2;
  logic [4:0]  shift;
  logic [31:0] alu_out;
  logic        done;
  logic        illegal;
  logic        busy;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  r_exec_sequencer #(.DATA_W(32), .NREGS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_valid(inst_valid),
    .inst_in   (inst_in),
    .inst_ready(inst_ready),
    .inst_reg  (inst_reg),
    .alu_i1    (alu_i1),
    .alu_i2    (alu_i2),
    .shift     (shift),
    .alu_out   (alu_out),
    .done      (done),
    .illegal   (illegal),
    .busy      (busy),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  function automatic logic [31:0] alu_ref(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (fn)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      FN_NOR:  return ~(a | b);
      FN_SLL:  return a << sh;
      FN_SRL:  return a >> sh;
      FN_SLT:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // The R-type ALU sits outside the sequencer.
  assign alu_out = alu_ref(inst_reg[5:0], alu_i1, alu_i2, shift);

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("R%0d", a), dbg_data, exp);
  endtask

  // Issues one word from an idle DUT and checks every cycle until idle again.
  task automatic issue(input logic [31:0] w);
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic        legal;
    logic [31:0] e1, e2;
    rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
    legal = (w[31:26] == 6'd0) && (fn >= 6'd32) && (fn <= 6'd40);
    e1 = model[rs];
    e2 = model[rt];
    chk("ready_idle", 32'(inst_ready), 32'd1);
    inst_valid = 1'b1;
    inst_in = w;
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
    inst_in = $urandom;
    chk("ready_t1", 32'(inst_ready), 32'd0);
    chk("busy_t1", 32'(busy), 32'd1);
    chk("illegal_t1", 32'(illegal), 32'(!legal));
    chk("done_t1", 32'(done), 32'd0);
    chk("inst_reg", inst_reg, w);
    @(negedge clk);
    if (!legal) begin
      chk("illegal_t2", 32'(illegal), 32'd0);
      chk("ready_t2_ill", 32'(inst_ready), 32'd1);
      chk("busy_t2_ill", 32'(busy), 32'd0);
      chk("done_t2_ill", 32'(done), 32'd0);
      read_reg(rd, model[rd]);
    end else begin
      chk("alu_i1", alu_i1, e1);
      chk("alu_i2", alu_i2, e2);
      chk("shift", 32'(shift), 32'(sh));
      chk("done_t2", 32'(done), 32'd0);
      @(negedge clk);
      chk("done_t3", 32'(done), 32'd1);
      chk("ready_t3", 32'(inst_ready), 32'd0);
      chk("illegal_t3", 32'(illegal), 32'd0);
      if (rd != 5'd0) model[rd] = alu_ref(fn, e1, e2, sh);
      @(negedge clk);
      chk("done_t4", 32'(done), 32'd0);
      chk("ready_t4", 32'(inst_ready), 32'd1);
      chk("busy_t4", 32'(busy), 32'd0);
      read_reg(rd, model[rd]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa, wb, w;
    logic [5:0]  fn, op;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst_n = 1'b0; inst_valid = 1'b0; inst_in = 32'd0; dbg_addr = 5'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(inst_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_inst_reg", inst_reg, 32'd0);
    chk("rst_alu_i1", alu_i1, 32'd0);
    chk("rst_alu_i2", alu_i2, 32'd0);
    chk("rst_shift", 32'(shift), 32'd0);
    read_reg(5'd5, 32'd0);

    // Build constants from zero: R9=1, R1=5, R2=7.
    @(negedge clk); issue(mk(6'd0, 5'd0, 5'd0, 5'd9, 5'd0, FN_NOR));
    @(negedge clk); issue(mk(6'd0, 5'd0, 5'd9, 5'd9, 5'd0, FN_SUB));
    @(negedge clk); issue(mk(6'd0, 5'd9, 5'd0, 5'd2, 5'd2, FN_SLL));
    @(negedge clk); issue(mk(6'd0, 5'd2, 5'd9, 5'd1, 5'd0, FN_ADD));
    @(negedge clk); issue(mk(6'd0, 5'd9, 5'd0, 5'd2, 5'd1, FN_SLL));
    @(negedge clk); issue(mk(6'd0, 5'd1, 5'd2, 5'd2, 5'd0, FN_ADD));
    read_reg(5'd1, 32'd5);
    read_reg(5'd2, 32'd7);

    @(negedge clk); issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD));
    read_reg(5'd3, 32'd12);
    @(negedge clk); issue(mk(6'd0, 5'd0, 5'd9, 5'd4, 5'd0, FN_SUB));
    read_reg(5'd4, 32'hFFFF_FFFF);
    @(negedge clk); issue(mk(6'd0, 5'd4, 5'd1, 5'd3, 5'd0, FN_SLT));
    read_reg(5'd3, 32'd0);
    @(negedge clk); issue(mk(6'd0, 5'd1, 5'd4, 5'd12, 5'd0, FN_SLT));
    read_reg(5'd12, 32'd1);
    @(negedge clk); issue(mk(6'd0, 5'd1, 5'd0, 5'd5, 5'd4, FN_SLL));
    read_reg(5'd5, 32'h50);
    @(negedge clk); issue(mk(6'd0, 5'd5, 5'd0, 5'd13, 5'd4, FN_SRL));
    read_reg(5'd13, 32'd5);
    @(negedge clk); issue(mk(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, FN_ADD));
    read_reg(5'd0, 32'd0);
    @(negedge clk); issue(mk(6'h23, 5'd1, 5'd2, 5'd14, 5'd0, FN_ADD));
    read_reg(5'd14, 32'd0);
    @(negedge clk); issue(mk(6'd0, 5'd1, 5'd2, 5'd12, 5'd0, 6'd41));
    read_reg(5'd12, 32'd1);

    // Valid held high across a RAW pair; the second word waits for ready.
    @(negedge clk);
    wa = mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, FN_ADD);
    wb = mk(6'd0, 5'd6, 5'd6, 5'd7, 5'd0, FN_ADD);
    inst_valid = 1'b1; inst_in = wa;
    @(posedge clk); @(negedge clk);
    inst_in = wb;
    chk("b2b_inst_t1", inst_reg, wa);
    @(negedge clk);
    chk("b2b_inst_t2", inst_reg, wa);
    chk("b2b_ready_t2", 32'(inst_ready), 32'd0);
    @(negedge clk);
    chk("b2b_done_a", 32'(done), 32'd1);
    chk("b2b_inst_t3", inst_reg, wa);
    @(negedge clk);
    chk("b2b_ready_t4", 32'(inst_ready), 32'd1);
    chk("b2b_inst_t4", inst_reg, wa);
    @(negedge clk);
    chk("b2b_inst_t5", inst_reg, wb);
    chk("b2b_ready_t5", 32'(inst_ready), 32'd0);
    inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done_b", 32'(done), 32'd1);
    @(negedge clk);
    model[6] = model[1] + model[2];
    model[7] = model[6] + model[6];
    read_reg(5'd6, 32'd12);
    read_reg(5'd7, 32'd24);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      fn = 6'($urandom_range(32, 40));
      op = 6'd0;
      case ($urandom_range(0, 7))
        0: op = 6'($urandom_range(1, 63));
        1: fn = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 31)) : 6'($urandom_range(41, 63));
        default: ;
      endcase
      w = mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn);
      @(negedge clk);
      issue(w);
    end
    for (int i = 0; i < 32; i++) read_reg(5'(i), model[i]);

    // Reset during EXEC of an add into R8.
    @(negedge clk);
    inst_valid = 1'b1; inst_in = mk(6'd0, 5'd1, 5'd2, 5'd8, 5'd0, FN_ADD);
    @(posedge clk); @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_inst_reg", inst_reg, 32'd0);
    chk("mid_rst_alu_i1", alu_i1, 32'd0);
    chk("mid_rst_alu_i2", alu_i2, 32'd0);
    chk("mid_rst_shift", 32'(shift), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_illegal", 32'(illegal), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    for (int i = 0; i < 32; i++) read_reg(5'(i), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(inst_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    read_reg(5'd8, 32'd0);
    @(negedge clk); issue(mk(6'd0, 5'd0, 5'd0, 5'd8, 5'd0, FN_NOR));
    read_reg(5'd8, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r_exec_sequencer.md
Name: r_exec_sequencer

Overview:
Multi-cycle issue/writeback controller that sits on the operand side of the R-type ALU. It accepts 32-bit R-format instruction words over a valid/ready handshake and reads rs and rt from an internal 32x32 register file. It drives the ALU's instruction, operand and shift inputs, captures the ALU result, and writes it back to rd. One instruction is in flight at a time, so there are no hazards.

Parameters:
DATA_W, 32, register and operand width
NREGS, 32, register count (address width fixed at 5 bits)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  instruction source has a word
inst_in  in  32  instruction word
inst_ready  out  1  sequencer can accept; high only in IDLE
inst_reg  out  32  latched instruction to ALU
alu_i1  out  DATA_W  operand 1 = R[rs]
alu_i2  out  DATA_W  operand 2 = R[rt]
shift  out  5  shamt field inst[10:6]
alu_out  in  DATA_W  ALU result, combinational from the above
done  out  1  one-cycle pulse on writeback cycle
illegal  out  1  one-cycle pulse: non-R opcode or unsupported funct
busy  out  1  high in any state except IDLE
dbg_addr  in  5  debug register read address
dbg_data  out  DATA_W  R[dbg_addr], combinational

Behaviour:
- Field decode:
  - opcode inst[31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
  - Legal only if opcode==0 and funct in 32..40.
- Reset:
  - FSM goes to IDLE. inst_reg, alu_i1, alu_i2, shift are 0. done, illegal, busy are 0. inst_ready is 1 after reset release.
  - All registers clear to 0.
  - Reset mid-operation abandons the instruction with no writeback.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: inst_ready=1. On inst_valid&inst_ready, latch inst_in into inst_reg and go to DECODE. The word is accepted on that edge.
  - DECODE: register alu_i1=R[rs], alu_i2=R[rt], shift=shamt. If illegal, pulse illegal for this cycle and return to IDLE with no write and no done.
  - EXEC: ALU inputs are stable. Capture alu_out into an internal result register at the end of the cycle.
  - WB: write result to R[rd] unless rd==0. Pulse done. Return to IDLE.
- Latency and throughput:
  - Acceptance edge t. done is high during cycle t+3. The write is visible on dbg_data from cycle t+4.
  - inst_ready rises again in cycle t+4, so throughput is one instruction per 4 cycles.
- Register 0 reads as 0 always. Writes to it are discarded but done still pulses.
- Arithmetic is the ALU's: modulo 2^32 wrap, unsigned slt, shift amount 0..31. The sequencer adds no checking.
- inst_valid while busy is ignored, with no capture. The source holds the word until it sees ready.
- Register file writes happen only in WB, one write port. It has two synchronous-use read ports plus the debug port.
- inst_reg, alu_i1, alu_i2 and shift hold their values from DECODE until the next DECODE.

Decomposition:
- Shared package: opcode/funct constants (FN_ADD=32 … FN_SLT=40, OP_RTYPE=0), field bit-position constants, FSM state encoding.
- One sub-module, r_regfile: 32 x DATA_W, async active-low clear, 1 write port, 3 combinational read ports, register 0 hardwired to 0.
- Instantiate the R-type ALU in the bench, not inside this block.

Test Plan:
- Reset, then preload via writes: R1=5, R2=7. Issue add (funct 32, rs=1, rt=2, rd=3) -> done at t+3, dbg R3=12, inst_ready back at t+4.
- sub with R1=0, R2=1, rd=4 -> R4=0xFFFFFFFF (wrap). Then slt R4<R1 -> 0 (unsigned compare).
- sll rs=1 (5), shamt=4, rd=5 -> R5=0x50. srl R5 by 4 -> 5.
- rd=0 with add -> done pulses, R0 still reads 0. Opcode=0x23 -> illegal pulses in DECODE, no done, no register change, ready after 2 cycles.
- Back-to-back valid held high with a RAW chain: R6=R1+R2, then R7=R6+R6 -> R7=24. Verify no word is accepted while busy.
- Assert rst_n low during EXEC of an add targeting R8 -> no write, all registers 0, outputs at reset values, IDLE on release.
